ds_n_arb: RTL and testbench



---
 rtl/ds_n_arb.sv | 141 ++++++++++++++
 tb/tb_ds_n_arb.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ds_n_arb.sv
//------------------------------------------------------------------------------
// Module   : ds_n_arb
// Brief    : N-channel, WIDTH-bit registered data selector with per-channel
//            valid/ready handshakes, a one-entry output register, and either
//            direct (explicit select) or round-robin channel selection.
//            Optional transfer counter enabled by defining DS_XFER_CNT_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ds_n_arb #(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  parameter int SELW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic [SELW-1:0]      select,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_ch,
  output logic                 out_valid,
  input  logic                 out_ready
`ifdef DS_XFER_CNT_EN
  ,
  output logic [15:0]          xfer_cnt
`endif
);

  localparam logic [SELW-1:0] LAST_RST = SELW'(NCH - 1);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_ch_q, out_ch_d;
  logic             out_valid_q, out_valid_d;
  logic [SELW-1:0]  last_q, last_d;

  logic [NCH-1:0]   grant;
  logic             load;
  logic             xfer;
  logic [WIDTH-1:0] sel_data;
  logic [SELW-1:0]  sel_ch;

  // The output register can accept a word when empty or being drained now.
  assign load = !out_valid_q || out_ready;

  // Grant generation: one-hot or zero. Direct mode never matches an index
  // >= NCH because only real channel indices are compared against select.
  // Round-robin walks priorities from lowest to highest so the highest
  // priority valid channel (last+1 onward) is written last and wins.
  always_comb begin
    int idx;
    grant = '0;
    idx   = 0;
    if (!mode) begin
      for (int i = 0; i < NCH; i++) begin
        if (SELW'(i) == select) grant[i] = in_valid[i];
      end
    end else begin
      for (int k = NCH; k >= 1; k--) begin
        idx = int'(last_q) + k;
        if (idx >= NCH) idx = idx - NCH;
        for (int i = 0; i < NCH; i++) begin
          if (i == idx && in_valid[i]) begin
            grant    = '0;
            grant[i] = 1'b1;
          end
        end
      end
    end
  end

  assign in_ready = load ? grant : '0;
  assign xfer     = |(in_ready & in_valid);

  // Data/index mux driven by the one-hot grant.
  always_comb begin
    sel_data = '0;
    sel_ch   = '0;
    for (int i = 0; i < NCH; i++) begin
      if (grant[i]) begin
        sel_data = in_data[i*WIDTH +: WIDTH];
        sel_ch   = SELW'(i);
      end
    end
  end

  // Next-state for the output register and round-robin pointer.
  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    last_d      = last_q;
    if (xfer) begin
      out_data_d  = sel_data;
      out_ch_d    = sel_ch;
      out_valid_d = 1'b1;
      if (mode) last_d = sel_ch;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State register; reset makes channel 0 first in round-robin order.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      last_q      <= LAST_RST;
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      last_q      <= last_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

`ifdef DS_XFER_CNT_EN
  logic [15:0] xfer_cnt_q, xfer_cnt_d;

  assign xfer_cnt_d = xfer ? xfer_cnt_q + 16'd1 : xfer_cnt_q;

  // Free-running transfer counter, wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (rst) xfer_cnt_q <= '0;
    else     xfer_cnt_q <= xfer_cnt_d;
  end

  assign xfer_cnt = xfer_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ds_n_arb.sv
//------------------------------------------------------------------------------
// Module   : tb_ds_n_arb
// Brief    : Directed self-checking bench for ds_n_arb (NCH=4, SELW=3 so an
//            out-of-range select can be exercised). Optional counter checks
//            are compiled when DS_XFER_CNT_EN is defined.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ds_n_arb;

  localparam int WIDTH = 32;
  localparam int NCH   = 4;
  localparam int SELW  = 3;

  logic                 clk;
  logic                 rst;
  logic                 mode;
  logic [SELW-1:0]      select;
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_ready;
  logic [WIDTH-1:0]     out_data;
  logic [SELW-1:0]      out_ch;
  logic                 out_valid;
  logic                 out_ready;
`ifdef DS_XFER_CNT_EN
  logic [15:0]          xfer_cnt;
`endif

  int checks;
  int failures;

  ds_n_arb #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .select    (select),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef DS_XFER_CNT_EN
    ,
    .xfer_cnt  (xfer_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input logic [31:0] d0, input logic [31:0] d1,
                          input logic [31:0] d2, input logic [31:0] d3);
    in_data = {d3, d2, d1, d0};
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 1'b0; select = '0; in_valid = '0; out_ready = 1'b1;
    set_data(32'hA, 32'hB, 32'hC, 32'hD);
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    checks++; if (out_ch !== 3'd0) begin failures++; $display("FAIL reset_out_ch got=%0d exp=0", out_ch); end
    checks++; if (in_ready !== 4'b0000) begin failures++; $display("FAIL reset_in_ready got=%b exp=0000", in_ready); end
`ifdef DS_XFER_CNT_EN
    checks++; if (xfer_cnt !== 16'd0) begin failures++; $display("FAIL reset_xfer_cnt got=%0d exp=0", xfer_cnt); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_direct();
    mode = 1'b0; select = 3'd2; in_valid = 4'b0110; out_ready = 1'b1;
    set_data(32'h11, 32'h22, 32'h33, 32'h44);
    #1;
    checks++; if (in_ready !== 4'b0100) begin failures++; $display("FAIL direct_ready got=%b exp=0100", in_ready); end
    tick();
    checks++; if (out_data !== 32'h33) begin failures++; $display("FAIL direct_data got=%h exp=33", out_data); end
    checks++; if (out_ch !== 3'd2) begin failures++; $display("FAIL direct_ch got=%0d exp=2", out_ch); end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL direct_valid got=%0b exp=1", out_valid); end
    // Selecting a channel whose valid is low grants nothing.
    select = 3'd0;
    #1;
    checks++; if (in_ready !== 4'b0000) begin failures++; $display("FAIL direct_novalid_ready got=%b exp=0000", in_ready); end
    // Out-of-range select.
    select = 3'd5;
    #1;
    checks++; if (in_ready !== 4'b0000) begin failures++; $display("FAIL direct_oor_ready got=%b exp=0000", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL direct_oor_valid got=%0b exp=0", out_valid); end
    checks++; if (out_data !== 32'h33) begin failures++; $display("FAIL direct_hold_data got=%h exp=33", out_data); end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_seq [6];
    exp_seq = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1};
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    set_data(32'h10, 32'h11, 32'h12, 32'h13);
    for (int n = 0; n < 6; n++) begin
      #1;
      checks++; if (in_ready !== (4'b0001 << exp_seq[n])) begin failures++; $display("FAIL rr_ready[%0d] got=%b exp_ch=%0d", n, in_ready, exp_seq[n]); end
      tick();
      checks++; if (out_ch !== exp_seq[n]) begin failures++; $display("FAIL rr_ch[%0d] got=%0d exp=%0d", n, out_ch, exp_seq[n]); end
      checks++; if (out_data !== 32'h10 + 32'(exp_seq[n])) begin failures++; $display("FAIL rr_data[%0d] got=%h exp=%h", n, out_data, 32'h10 + 32'(exp_seq[n])); end
    end
  endtask

  task automatic test_backpressure();
    // last=1 now; next grant is channel 2 carrying 0xFF.
    set_data(32'h10, 32'h11, 32'hFF, 32'h13);
    tick();
    checks++; if (out_data !== 32'hFF || out_ch !== 3'd2) begin failures++; $display("FAIL bp_load got=%h/%0d exp=ff/2", out_data, out_ch); end
    out_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      #1;
      checks++; if (in_ready !== 4'b0000) begin failures++; $display("FAIL bp_ready[%0d] got=%b exp=0000", n, in_ready); end
      tick();
      checks++; if (out_data !== 32'hFF || out_valid !== 1'b1 || out_ch !== 3'd2) begin failures++; $display("FAIL bp_hold[%0d] got=%h/%0b/%0d exp=ff/1/2", n, out_data, out_valid, out_ch); end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 4'b1000) begin failures++; $display("FAIL bp_release_ready got=%b exp=1000", in_ready); end
    tick();
    checks++; if (out_ch !== 3'd3 || out_data !== 32'h13) begin failures++; $display("FAIL bp_release_out got=%0d/%h exp=3/13", out_ch, out_data); end
  endtask

  task automatic test_rr_skip();
    // last=3: sparse valids skip idle channels and wrap past NCH-1.
    set_data(32'h10, 32'h11, 32'h12, 32'h13);
    in_valid = 4'b0101;
    #1;
    checks++; if (in_ready !== 4'b0001) begin failures++; $display("FAIL skip_a got=%b exp=0001", in_ready); end
    tick();
    checks++; if (in_ready !== 4'b0100) begin failures++; $display("FAIL skip_b got=%b exp=0100", in_ready); end
    tick();
    in_valid = 4'b0001;
    #1;
    checks++; if (in_ready !== 4'b0001) begin failures++; $display("FAIL skip_wrap got=%b exp=0001", in_ready); end
    tick();
    checks++; if (out_ch !== 3'd0 || out_data !== 32'h10) begin failures++; $display("FAIL skip_out got=%0d/%h exp=0/10", out_ch, out_data); end
  endtask

  task automatic test_reset_mid();
    in_valid = 4'b0100;
    tick();  // last=2, out_valid=1
    checks++; if (out_valid !== 1'b1 || out_ch !== 3'd2) begin failures++; $display("FAIL mid_pre got=%0b/%0d exp=1/2", out_valid, out_ch); end
    rst = 1'b1; in_valid = 4'b1111;
    tick();
    checks++; if (out_valid !== 1'b0 || out_data !== 32'h0 || out_ch !== 3'd0) begin failures++; $display("FAIL mid_reset got=%0b/%h/%0d exp=0/0/0", out_valid, out_data, out_ch); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 4'b0001) begin failures++; $display("FAIL mid_first_grant got=%b exp=0001", in_ready); end
    tick();
    checks++; if (out_ch !== 3'd0 || out_data !== 32'h10) begin failures++; $display("FAIL mid_first_out got=%0d/%h exp=0/10", out_ch, out_data); end
  endtask

`ifdef DS_XFER_CNT_EN
  task automatic test_xfer_cnt();
    rst = 1'b1; tick(); rst = 1'b0;
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    for (int n = 0; n < 5; n++) tick();
    in_valid = 4'b0000;
    tick();
    checks++; if (xfer_cnt !== 16'd5) begin failures++; $display("FAIL cnt_five got=%0d exp=5", xfer_cnt); end
    rst = 1'b1; tick(); rst = 1'b0;
    in_valid = 4'b1111;
    for (int n = 0; n < 65536; n++) tick();
    in_valid = 4'b0000;
    tick();
    checks++; if (xfer_cnt !== 16'd0) begin failures++; $display("FAIL cnt_wrap got=%0d exp=0", xfer_cnt); end
  endtask
`endif

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; mode = 1'b0; select = '0; in_valid = '0; in_data = '0; out_ready = 1'b0;
    #2;
    test_reset();
    test_direct();
    test_round_robin();
    test_backpressure();
    test_rr_skip();
    test_reset_mid();
`ifdef DS_XFER_CNT_EN
    test_xfer_cnt();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
